// File: rtl/button_debounce_pulser_pkg.sv
// Shared board timing for the Go Board button front-ends: clock rate, derived default
// debounce/repeat cycle counts, and counter sizing helpers.
package button_debounce_pulser_pkg;

  localparam int unsigned CLK_HZ = 25_000_000;

  // 10 ms debounce, 500 ms first-repeat delay, 100 ms repeat period
  localparam int unsigned DEBOUNCE_CYCLES_DEF     = CLK_HZ / 100;
  localparam int unsigned REPEAT_DELAY_CYCLES_DEF = CLK_HZ / 2;
  localparam int unsigned REPEAT_RATE_CYCLES_DEF  = CLK_HZ / 10;

  function automatic int unsigned maxOf3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int unsigned counterWidth(input int unsigned maxVal);
    return $clog2(maxVal) + 1;
  endfunction

endpackage

// File: rtl/button_debounce_pulser_sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset; reusable for any
// asynchronous board input.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic s1;
  logic s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_d;
      s2 <= s1;
    end
  end

  assign o_q = s2;

endmodule

// File: rtl/button_debounce_pulser.sv
// Push-button front-end: synchronise, debounce, and emit one-cycle press/release/repeat
// pulses plus an event strobe for the downstream counter.
module button_debounce_pulser
  import button_debounce_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_EN           = 1,
  parameter int unsigned REPEAT_DELAY_CYCLES = REPEAT_DELAY_CYCLES_DEF,
  parameter int unsigned REPEAT_RATE_CYCLES  = REPEAT_RATE_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_debounced,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_repeat_pulse,
  output logic o_event
);

  localparam int unsigned CNT_W =
    counterWidth(maxOf3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
  localparam bit               REP_ON     = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } btnState_e;

  btnState_e        state, stateNext;
  logic [CNT_W-1:0] dcnt, dcntNext;
  logic [CNT_W-1:0] rcnt, rcntNext;
  logic             btnSync;

  logic debouncedNext;
  logic pressNext;
  logic releaseNext;
  logic repeatNext;
  logic eventNext;

  sync_2ff uSync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_button),
    .o_q   (btnSync)
  );

  // State, counters and all outputs share one register stage so pulses align with the level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      dcnt            <= '0;
      rcnt            <= '0;
      o_debounced     <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_repeat_pulse  <= 1'b0;
      o_event         <= 1'b0;
    end else begin
      state           <= stateNext;
      dcnt            <= dcntNext;
      rcnt            <= rcntNext;
      o_debounced     <= debouncedNext;
      o_press_pulse   <= pressNext;
      o_release_pulse <= releaseNext;
      o_repeat_pulse  <= repeatNext;
      o_event         <= eventNext;
    end
  end

  always_comb begin
    stateNext = state;
    dcntNext  = dcnt;
    rcntNext  = rcnt;
    unique case (state)
      IDLE: begin
        if (btnSync) begin
          stateNext = PRESS_WAIT;
          dcntNext  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btnSync) begin
          stateNext = IDLE;
        end else if (dcnt == DEB_LAST) begin
          stateNext = HELD;
          rcntNext  = '0;
        end else begin
          dcntNext = dcnt + 1'b1;
        end
      end
      HELD: begin
        if (!btnSync) begin
          stateNext = RELEASE_WAIT;
          dcntNext  = '0;
        end else if (REP_ON && rcnt == DELAY_LAST) begin
          stateNext = REPEAT;
          rcntNext  = '0;
        end else if (REP_ON) begin
          rcntNext = rcnt + 1'b1;
        end
      end
      REPEAT: begin
        if (!btnSync) begin
          stateNext = RELEASE_WAIT;
          dcntNext  = '0;
        end else if (rcnt == RATE_LAST) begin
          rcntNext = '0;
        end else begin
          rcntNext = rcnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // Re-contact returns to HELD, so the repeat delay restarts from zero.
        if (btnSync) begin
          stateNext = HELD;
          rcntNext  = '0;
        end else if (dcnt == DEB_LAST) begin
          stateNext = IDLE;
        end else begin
          dcntNext = dcnt + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        dcntNext  = '0;
        rcntNext  = '0;
      end
    endcase
  end

  always_comb begin
    pressNext   = (state == PRESS_WAIT) && btnSync && (dcnt == DEB_LAST);
    releaseNext = (state == RELEASE_WAIT) && !btnSync && (dcnt == DEB_LAST);
    repeatNext  = btnSync &&
                  (((state == HELD) && REP_ON && (rcnt == DELAY_LAST)) ||
                   ((state == REPEAT) && (rcnt == RATE_LAST)));
    eventNext   = pressNext || repeatNext;
    debouncedNext = o_debounced;
    if (pressNext)   debouncedNext = 1'b1;
    if (releaseNext) debouncedNext = 1'b0;
  end

endmodule

// File: tb/tb_button_debounce_pulser.sv
// Directed bench: two instances (repeat on / off) share stimulus; a cycle-stamped queue of
// expected pulses is compared against both every cycle.
module tb_button_debounce_pulser;

  logic clk;
  logic rst;
  logic button;

  logic deb1, press1, rel1, rep1, evt1;
  logic deb2, press2, rel2, rep2, evt2;

  typedef struct {
    int at;
    bit press;
    bit rel;
    bit rep;
  } expEvt_t;

  expEvt_t sb[$];
  int      cyc;
  int      checks;
  int      failures;
  bit      expLevel;

  button_debounce_pulser #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_EN           (1),
    .REPEAT_DELAY_CYCLES (8),
    .REPEAT_RATE_CYCLES  (3)
  ) dutRep (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_button        (button),
    .o_debounced     (deb1),
    .o_press_pulse   (press1),
    .o_release_pulse (rel1),
    .o_repeat_pulse  (rep1),
    .o_event         (evt1)
  );

  button_debounce_pulser #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_EN           (0),
    .REPEAT_DELAY_CYCLES (8),
    .REPEAT_RATE_CYCLES  (3)
  ) dutNoRep (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_button        (button),
    .o_debounced     (deb2),
    .o_press_pulse   (press2),
    .o_release_pulse (rel2),
    .o_repeat_pulse  (rep2),
    .o_event         (evt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int at, input bit p, input bit r, input bit rp);
    expEvt_t e;
    e.at = at; e.press = p; e.rel = r; e.rep = rp;
    sb.push_back(e);
  endtask

  // Bit order: {debounced, press, release, repeat, event}
  task automatic compare(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
  endtask

  task automatic checkCycle();
    bit eP, eR, eRp;
    eP = 0; eR = 0; eRp = 0;
    while (sb.size() > 0 && sb[0].at == cyc) begin
      eP  |= sb[0].press;
      eR  |= sb[0].rel;
      eRp |= sb[0].rep;
      void'(sb.pop_front());
    end
    if (eP) expLevel = 1'b1;
    if (eR) expLevel = 1'b0;
    compare("dut_rep",   {deb1, press1, rel1, rep1, evt1}, {expLevel, eP, eR, eRp, eP | eRp});
    compare("dut_norep", {deb2, press2, rel2, rep2, evt2}, {expLevel, eP, eR, 1'b0, eP});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      checkCycle();
    end
  endtask

  initial begin
    int p, c, q;
    cyc = 0; checks = 0; failures = 0; expLevel = 1'b0;
    rst = 1'b1;
    button = 1'b1;

    // Reset held with the button pressed: outputs stay 0
    tick(3);
    rst = 1'b0;
    p = cyc + 7;
    push(p, 1, 0, 0);
    // Held 40 cycles past the press; repeats visible up to two edges after the raw release
    for (int t = p + 8; t <= p + 42; t += 3) push(t, 0, 0, 1);
    tick(p + 40 - cyc);

    // Release with a one-cycle re-contact inside the window
    c = cyc;
    button = 1'b0;
    tick(2);
    button = 1'b1;
    tick(1);
    button = 1'b0;
    push(cyc + 7, 0, 1, 0);
    tick(12);

    // Bouncy press: 3 high, 2 low, then stable high
    button = 1'b1;
    tick(3);
    button = 1'b0;
    tick(2);
    button = 1'b1;
    q = cyc + 7;
    push(q, 1, 0, 0);
    push(q + 8, 0, 0, 1);
    tick(q + 9 - cyc);

    // Async reset while in REPEAT
    rst = 1'b1;
    #1;
    expLevel = 1'b0;
    compare("async_rst_dut_rep",   {deb1, press1, rel1, rep1, evt1}, 5'b00000);
    compare("async_rst_dut_norep", {deb2, press2, rel2, rep2, evt2}, 5'b00000);
    button = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(15);

    checks++;
    assert (sb.size() === 0)
      else begin
        failures++;
        $error("FAIL scoreboard_drain pending=%0d expected=0 (c=%0d)", sb.size(), c);
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
